// File: rtl/dmem_arbiter.sv
// Two-port (core = port 0, DMA = port 1) round-robin arbiter in front of a single data memory.
// Each accepted request walks IDLE -> ACCESS -> RESP, one cycle per phase.
module dmem_arbiter #(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_gnt,
    output logic          p0_done,
    output logic [31:0]   p0_rdata,
    output logic          p0_err,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_gnt,
    output logic          p1_done,
    output logic [31:0]   p1_rdata,
    output logic          p1_err,

    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

    state_t        r_state;
    logic          r_lastWinner;
    logic          r_port;
    logic          r_we;
    logic          r_err;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;

    logic          w_idle;
    logic          w_access;
    logic          w_resp;
    logic          w_winner;
    logic          w_anyGnt;
    logic          w_selWe;
    logic [AW-1:0] w_selAddr;
    logic [31:0]   w_selWdata;
    logic          w_inRange;

    assign w_idle   = (r_state == IDLE)   && !reset;
    assign w_access = (r_state == ACCESS) && !reset;
    assign w_resp   = (r_state == RESP)   && !reset;

    // Lone requester wins outright; on contention the port that did not win last time goes.
    always_comb begin
        w_winner = 1'b0;
        if (p0_req && p1_req) begin
            w_winner = ~r_lastWinner;
        end else if (p1_req) begin
            w_winner = 1'b1;
        end
    end

    assign p0_gnt   = w_idle && p0_req && !w_winner;
    assign p1_gnt   = w_idle && p1_req &&  w_winner;
    assign w_anyGnt = p0_gnt || p1_gnt;

    assign w_selWe    = w_winner ? p1_we    : p0_we;
    assign w_selAddr  = w_winner ? p1_addr  : p0_addr;
    assign w_selWdata = w_winner ? p1_wdata : p0_wdata;
    assign w_inRange  = ({1'b0, w_selAddr} < DEPTH_EXT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lastWinner <= 1'b1;
            r_port       <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyGnt) begin
                        r_port       <= w_winner;
                        r_lastWinner <= w_winner;
                        r_we         <= w_selWe;
                        r_addr       <= w_selAddr;
                        r_wdata      <= w_selWdata;
                        r_err        <= !w_inRange;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Writes and rejected addresses return zero rather than whatever the memory drives.
                    r_rdata <= (r_we || r_err) ? 32'h0 : mem_rdata;
                    r_state <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = (w_access || w_resp) ? r_addr : '0;
    assign mem_wdata = reset ? 32'h0 : r_wdata;
    assign mem_we    = w_access && r_we && !r_err;

    assign p0_done  = w_resp && !r_port;
    assign p0_rdata = p0_done ? r_rdata : 32'h0;
    assign p0_err   = p0_done && r_err;

    assign p1_done  = w_resp && r_port;
    assign p1_rdata = p1_done ? r_rdata : 32'h0;
    assign p1_err   = p1_done && r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a transaction-level model.
module tb_dmem_arbiter;

    localparam int DEPTH = 32;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [31:0]   p0_wdata, p1_wdata;
    logic          p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
    logic [31:0]   p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_we;

    logic [31:0]   memArray [DEPTH];
    logic          memInit;
    logic [31:0]   memSeed;

    int testCount;
    int failCount;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Environment memory: combinational read, posedge write, bulk fill on memInit.
    assign mem_rdata = (mem_addr < 32'(DEPTH)) ? memArray[mem_addr[4:0]] : 32'h0;

    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < DEPTH; i++) memArray[i] <= memSeed + 32'(i);
        end else if (mem_we && (mem_addr < 32'(DEPTH))) begin
            memArray[mem_addr[4:0]] <= mem_wdata;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expMemWe;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t vecs [8];

    // Random-phase requester and model state.
    logic        hold [2];
    logic        rq [2];
    logic        wq [2];
    logic [31:0] aq [2];
    logic [31:0] dq [2];
    logic [31:0] refMem [DEPTH];
    int          cyc, freeAt, txnGrant, lastWin, winner;
    bit          txnValid, txnPort, txnWe, txnInRange, rstNow;
    logic [31:0] txnAddr, txnWdata, txnRd;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst,
                                 input logic r0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic we1, input logic [31:0] a1, input logic [31:0] d1);
        reset = rst;
        p0_req = r0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic runVector(input int idx);
        vec_t v;
        v = vecs[idx];
        if (v.port) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, v.we, v.addr, v.wdata);
        else        applyStimulus(1'b0, 1'b1, v.we, v.addr, v.wdata, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput($sformatf("vec%0d gnt", idx), 32'(v.port ? p1_gnt : p0_gnt), 32'd1);
        checkOutput($sformatf("vec%0d other gnt", idx), 32'(v.port ? p0_gnt : p1_gnt), 32'd0);
        checkOutput($sformatf("vec%0d we in gnt", idx), 32'(mem_we), 32'd0);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput($sformatf("vec%0d mem_addr", idx), mem_addr, v.addr);
        checkOutput($sformatf("vec%0d mem_we", idx), 32'(mem_we), 32'(v.expMemWe));
        if (v.expMemWe) checkOutput($sformatf("vec%0d mem_wdata", idx), mem_wdata, v.wdata);
        cycle();
        @(negedge clk);
        checkOutput($sformatf("vec%0d done", idx), 32'(v.port ? p1_done : p0_done), 32'd1);
        checkOutput($sformatf("vec%0d rdata", idx), v.port ? p1_rdata : p0_rdata, v.expRdata);
        checkOutput($sformatf("vec%0d err", idx), 32'(v.port ? p1_err : p0_err), 32'(v.expErr));
        checkOutput($sformatf("vec%0d other done", idx), 32'(v.port ? p0_done : p1_done), 32'd0);
        checkOutput($sformatf("vec%0d we in resp", idx), 32'(mem_we), 32'd0);
        cycle();
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        vecs[0] = '{port:1'b0, we:1'b0, addr:32'd5,          wdata:32'h0,        expMemWe:1'b0, expRdata:32'h5,        expErr:1'b0};
        vecs[1] = '{port:1'b1, we:1'b1, addr:32'd7,          wdata:32'hDEADBEEF, expMemWe:1'b1, expRdata:32'h0,        expErr:1'b0};
        vecs[2] = '{port:1'b0, we:1'b0, addr:32'd7,          wdata:32'h0,        expMemWe:1'b0, expRdata:32'hDEADBEEF, expErr:1'b0};
        vecs[3] = '{port:1'b0, we:1'b1, addr:32'd32,         wdata:32'h12345678, expMemWe:1'b0, expRdata:32'h0,        expErr:1'b1};
        vecs[4] = '{port:1'b0, we:1'b0, addr:32'hFFFFFFFF,   wdata:32'h0,        expMemWe:1'b0, expRdata:32'h0,        expErr:1'b1};
        vecs[5] = '{port:1'b1, we:1'b0, addr:32'd31,         wdata:32'h0,        expMemWe:1'b0, expRdata:32'd31,       expErr:1'b0};
        vecs[6] = '{port:1'b1, we:1'b1, addr:32'd31,         wdata:32'hA5A5A5A5, expMemWe:1'b1, expRdata:32'h0,        expErr:1'b0};
        vecs[7] = '{port:1'b0, we:1'b0, addr:32'd31,         wdata:32'h0,        expMemWe:1'b0, expRdata:32'hA5A5A5A5, expErr:1'b0};

        // Reset with both ports requesting: everything must stay quiet.
        memSeed = 32'h0;
        memInit = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd1, 32'h0, 1'b1, 1'b0, 32'd2, 32'h0);
        cycle();
        cycle();
        @(negedge clk);
        checkOutput("reset p0_gnt", 32'(p0_gnt), 32'd0);
        checkOutput("reset p1_gnt", 32'(p1_gnt), 32'd0);
        checkOutput("reset done", 32'({p0_done, p1_done, p0_err, p1_err}), 32'd0);
        checkOutput("reset rdata", p0_rdata | p1_rdata, 32'h0);
        checkOutput("reset mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset mem_wdata", mem_wdata, 32'h0);
        cycle();
        memInit = 1'b0;

        // Continuous contention from reset release: p0 first, then alternate every 3 cycles.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd1, 32'h0, 1'b1, 1'b0, 32'd2, 32'h0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checkOutput($sformatf("cont k%0d gnt0", k), 32'(p0_gnt), 32'((k % 6) == 0));
            checkOutput($sformatf("cont k%0d gnt1", k), 32'(p1_gnt), 32'((k % 6) == 3));
            checkOutput($sformatf("cont k%0d done0", k), 32'(p0_done), 32'((k % 6) == 2));
            checkOutput($sformatf("cont k%0d done1", k), 32'(p1_done), 32'((k % 6) == 5));
            if ((k % 6) == 2) checkOutput($sformatf("cont k%0d rdata0", k), p0_rdata, 32'd1);
            if ((k % 6) == 5) checkOutput($sformatf("cont k%0d rdata1", k), p1_rdata, 32'd2);
            cycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();

        for (int i = 0; i < 8; i++) runVector(i);

        // Reset in the ACCESS cycle of a p1 write aborts it.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'd9, 32'h99999999);
        @(negedge clk);
        checkOutput("abort p1_gnt", 32'(p1_gnt), 32'd1);
        cycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("abort mem_we", 32'(mem_we), 32'd0);
        checkOutput("abort mem_addr", mem_addr, 32'h0);
        checkOutput("abort p1_done in rst", 32'(p1_done), 32'd0);
        cycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd4, 32'h0, 1'b1, 1'b0, 32'd6, 32'h0);
        @(negedge clk);
        checkOutput("abort p1_done after", 32'(p1_done), 32'd0);
        checkOutput("abort idle p0_gnt", 32'(p0_gnt), 32'd1);
        checkOutput("abort idle p1_gnt", 32'(p1_gnt), 32'd0);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("abort p1_done late", 32'(p1_done), 32'd0);
        cycle();
        @(negedge clk);
        checkOutput("abort p0_done", 32'(p0_done), 32'd1);
        checkOutput("abort p0_rdata", p0_rdata, 32'd4);
        checkOutput("abort mem[9] kept", memArray[9], 32'd9);
        cycle();

        // A one-cycle p1 request while p0 is busy is never served.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd3, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("wd p0_gnt", 32'(p0_gnt), 32'd1);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd10, 32'h0);
        @(negedge clk);
        checkOutput("wd p1_gnt pulse", 32'(p1_gnt), 32'd0);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("wd p0_done", 32'(p0_done), 32'd1);
        checkOutput("wd p0_rdata", p0_rdata, 32'd3);
        for (int k = 0; k < 3; k++) begin
            cycle();
            @(negedge clk);
            checkOutput($sformatf("wd k%0d p1 activity", k), 32'({p1_gnt, p1_done}), 32'd0);
        end
        cycle();

        // Randomized traffic against a transaction-level model.
        memSeed = $urandom;
        memInit = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        memInit = 1'b0;
        for (int i = 0; i < DEPTH; i++) refMem[i] = memSeed + 32'(i);
        for (int p = 0; p < 2; p++) begin
            hold[p] = 1'b0; wq[p] = 1'b0; aq[p] = 32'h0; dq[p] = 32'h0;
        end
        txnValid = 1'b0; lastWin = 1; freeAt = 0; txnGrant = 0;
        txnPort = 1'b0; txnWe = 1'b0; txnInRange = 1'b0;
        txnAddr = 32'h0; txnWdata = 32'h0; txnRd = 32'h0;

        for (cyc = 0; cyc < 400; cyc++) begin
            rstNow = ($urandom_range(0, 49) == 0);
            for (int p = 0; p < 2; p++) begin
                if (hold[p]) begin
                    if ($urandom_range(0, 11) == 0) hold[p] = 1'b0;
                end else if ($urandom_range(0, 99) < 45) begin
                    hold[p] = 1'b1;
                    wq[p] = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 9))
                        0:       aq[p] = 32'(DEPTH);
                        1:       aq[p] = $urandom;
                        default: aq[p] = 32'($urandom_range(0, DEPTH - 1));
                    endcase
                    dq[p] = $urandom;
                end
                rq[p] = hold[p];
            end
            applyStimulus(rstNow, rq[0], wq[0], aq[0], dq[0], rq[1], wq[1], aq[1], dq[1]);
            @(negedge clk);

            begin
                bit accessNow, respNow, g0, g1;
                winner = (rq[0] && rq[1]) ? (1 - lastWin) : (rq[1] ? 1 : 0);
                g0 = !rstNow && (cyc >= freeAt) && rq[0] && (winner == 0);
                g1 = !rstNow && (cyc >= freeAt) && rq[1] && (winner == 1);
                accessNow = txnValid && (cyc == txnGrant + 1) && !rstNow;
                respNow   = txnValid && (cyc == txnGrant + 2) && !rstNow;
                if (accessNow) txnRd = (txnWe || !txnInRange) ? 32'h0 : refMem[txnAddr[4:0]];

                checkOutput($sformatf("rand c%0d gnt0", cyc), 32'(p0_gnt), 32'(g0));
                checkOutput($sformatf("rand c%0d gnt1", cyc), 32'(p1_gnt), 32'(g1));
                checkOutput($sformatf("rand c%0d mem_we", cyc), 32'(mem_we), 32'(accessNow && txnWe && txnInRange));
                checkOutput($sformatf("rand c%0d mem_addr", cyc), mem_addr, (accessNow || respNow) ? txnAddr : 32'h0);
                if (accessNow && txnWe && txnInRange)
                    checkOutput($sformatf("rand c%0d mem_wdata", cyc), mem_wdata, txnWdata);
                checkOutput($sformatf("rand c%0d done0", cyc), 32'(p0_done), 32'(respNow && !txnPort));
                checkOutput($sformatf("rand c%0d done1", cyc), 32'(p1_done), 32'(respNow && txnPort));
                checkOutput($sformatf("rand c%0d rdata0", cyc), p0_rdata, (respNow && !txnPort) ? txnRd : 32'h0);
                checkOutput($sformatf("rand c%0d rdata1", cyc), p1_rdata, (respNow && txnPort) ? txnRd : 32'h0);
                checkOutput($sformatf("rand c%0d err0", cyc), 32'(p0_err), 32'(respNow && !txnPort && !txnInRange));
                checkOutput($sformatf("rand c%0d err1", cyc), 32'(p1_err), 32'(respNow && txnPort && !txnInRange));

                if (rstNow) begin
                    txnValid = 1'b0;
                    lastWin  = 1;
                    freeAt   = cyc + 1;
                end else begin
                    if (accessNow && txnWe && txnInRange) refMem[txnAddr[4:0]] = txnWdata;
                    if (respNow) txnValid = 1'b0;
                    if (g0 || g1) begin
                        txnValid   = 1'b1;
                        txnGrant   = cyc;
                        txnPort    = (winner == 1);
                        txnWe      = wq[winner];
                        txnAddr    = aq[winner];
                        txnWdata   = dq[winner];
                        txnInRange = (aq[winner] < 32'(DEPTH));
                        freeAt     = cyc + 3;
                        lastWin    = winner;
                        hold[winner] = 1'b0;
                    end
                end
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Parameters
REQ-001 The block SHALL have parameter DEPTH, default 32, meaning the number of words in the data memory.
REQ-002 The block SHALL have parameter AW, default 32, meaning the address width in bits.

Interface
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Port list (name, direction, width, meaning):
  clk  in  1  system clock, all logic on posedge
  reset  in  1  synchronous, active-high reset
  pN_req  in  1  port N (N=0 core, N=1 DMA) access request, level
  pN_we  in  1  port N: 1=write, 0=read
  pN_addr  in  AW  port N word address
  pN_wdata  in  32  port N write data
  pN_gnt  out  1  port N request accepted, 1-cycle pulse
  pN_done  out  1  port N access complete, 1-cycle pulse
  pN_rdata  out  32  port N read data, valid with pN_done
  pN_err  out  1  port N address out of range, valid with pN_done
  mem_addr  out  AW  word address to data memory
  mem_wdata  out  32  write data to data memory
  mem_we  out  1  write enable to data memory
  mem_rdata  in  32  combinational read data from data memory

Function
REQ-005 FSM states SHALL be IDLE, ACCESS and RESP, in that order per transaction; each of ACCESS and RESP SHALL last exactly 1 cycle.
REQ-006 IDLE: if any pN_req=1, the arbiter SHALL select a winner, pulse that port's pN_gnt in the same cycle, latch its we, addr, wdata and port id, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-007 Arbitration SHALL be round-robin: with one requester, that requester wins; with both, the port other than last_winner wins; last_winner SHALL update on every grant.
REQ-008 Requesters SHALL hold req, we, addr and wdata stable from req rise until gnt; the arbiter SHALL sample them only in the gnt cycle.
REQ-009 A request not granted SHALL remain pending with no pulse on the loser's gnt; a port that drops req before gnt SHALL get no transaction.
REQ-010 In-range test: addr_q < DEPTH, unsigned, full AW bits compared; err_q = NOT in-range, latched at grant.
REQ-011 mem_addr SHALL be addr_q in ACCESS and RESP, and 0 otherwise; mem_wdata SHALL equal wdata_q.
REQ-012 mem_we SHALL be combinational: 1 only when state=ACCESS AND we_q=1 AND err_q=0 AND reset=0.
REQ-013 ACCESS: read data SHALL be captured from mem_rdata at the end of the cycle; for writes or err_q=1 the captured value SHALL be 0.
REQ-014 RESP: the winner's pN_done SHALL be 1 with pN_rdata = captured value and pN_err = err_q; the other port's done, rdata and err SHALL be 0; the next state SHALL be IDLE.
REQ-015 Outside RESP, every pN_done, pN_rdata and pN_err SHALL be 0.
REQ-016 Latency SHALL be 2 cycles from gnt to done; the maximum accept rate SHALL be one transaction per 3 cycles.
REQ-017 A pN_req held high through its own done SHALL be treated as a new request in the following IDLE cycle.
REQ-018 An out-of-range write SHALL never assert mem_we; an out-of-range read SHALL return rdata=0 and err=1.

Reset
REQ-019 While reset=1 at a posedge, the block SHALL set state=IDLE, last_winner=1 (port 0 wins the first contention) and clear all latched request registers to 0.
REQ-020 From the cycle reset is sampled, all outputs SHALL be 0: pN_gnt, pN_done, pN_rdata, pN_err, mem_addr, mem_wdata and mem_we.
REQ-021 Reset asserted during ACCESS SHALL suppress mem_we in that cycle, abort the transaction and produce no done pulse.
REQ-022 Reset SHALL override any request presented in the same cycle.

Verification
REQ-023 Single read: p0 read of addr 5 with mem word 5 = 0x5 -> p0_gnt at cycle t, mem_addr=5 at t+1, p0_done=1 with p0_rdata=0x5 and p0_err=0 at t+2.
REQ-024 Contention: p0 and p1 both request continuously from reset release -> grants go p0, p1, p0, p1, each 3 cycles apart, with no lost or duplicated done pulses.
REQ-025 Write then read: p1 writes 0xDEADBEEF to addr 7, then p0 reads addr 7 -> mem_we high for exactly 1 cycle, p1_rdata=0, then p0_rdata=0xDEADBEEF.
REQ-026 Out-of-range: p0 writes addr 32, then reads addr 0xFFFFFFFF -> mem_we never asserted; both done pulses carry err=1 and rdata=0.
REQ-027 Reset mid-operation: reset=1 in the ACCESS cycle of a p1 write -> mem_we=0 in that cycle, no p1_done, state=IDLE, memory content unchanged.
REQ-028 Request withdrawal: p1_req pulses for 1 cycle while the block is busy with p0 -> no p1_gnt and no p1_done.
